// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch : sequential fetch/issue stage with PC, redirect and halt
// Optional: HALT_RESUME_EN lets `resume` restart fetch from HALT.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_fetch #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  output logic [3:0]          Op_Code,
  output logic [11:0]         Operands,
  output logic                instr_valid,
  input  logic                stall,
  input  logic                redirect_en,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                resume,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE    = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]          OP_HALT   = 4'b1111;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_ONE;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          // Halt takes priority: a redirect on the halt word is dropped.
          if (ir_q[15:12] == OP_HALT) begin
            state_d = S_HALT;
          end else begin
            state_d = S_REQ;
            if (redirect_en) pc_d = redirect_pc;
          end
        end
      end
      S_HALT: begin
`ifdef HALT_RESUME_EN
        if (resume) state_d = S_REQ;
`else
        state_d = S_HALT;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifndef HALT_RESUME_EN
  logic unused_resume;
  assign unused_resume = resume;
`endif

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALT);
  assign Op_Code     = ir_q[15:12];
  assign Operands    = ir_q[11:0];
  assign pc          = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch : directed stimulus, observable-level model, per-cycle compare
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;

  localparam int         PW    = 8;
  localparam logic [7:0] RSTPC = 8'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [3:0]  Op_Code;
  logic [11:0] Operands;
  logic        instr_valid;
  logic        stall;
  logic        redirect_en;
  logic [7:0]  redirect_pc;
  logic        resume;
  logic [7:0]  pc;
  logic        halted;

  logic        ack_en;
  logic        force_ack;
  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_ack  = force_ack | (ack_en & imem_req);
  assign imem_data = mem[imem_addr];

  instr_fetch #(.PC_WIDTH(PW), .RESET_PC(RSTPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .Op_Code(Op_Code), .Operands(Operands), .instr_valid(instr_valid),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .resume(resume), .pc(pc), .halted(halted)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model tracks what each observable must be, advancing on the handshake rules.
  logic       m_idle, m_req, m_valid, m_halt;
  logic [7:0] m_pc;
  logic [15:0] m_ir;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle <= 1'b1; m_req <= 1'b0; m_valid <= 1'b0; m_halt <= 1'b0;
      m_pc   <= RSTPC; m_ir <= 16'h0000;
    end else if (m_idle) begin
      m_idle <= 1'b0; m_req <= 1'b1;
    end else if (m_req) begin
      if (imem_ack) begin
        m_ir    <= mem[m_pc];
        m_pc    <= m_pc + 8'd1;
        m_req   <= 1'b0;
        m_valid <= 1'b1;
      end
    end else if (m_valid) begin
      if (!stall) begin
        m_valid <= 1'b0;
        if (m_ir[15:12] == 4'hF) m_halt <= 1'b1;
        else begin
          m_req <= 1'b1;
          if (redirect_en) m_pc <= redirect_pc;
        end
      end
    end else if (m_halt) begin
`ifdef HALT_RESUME_EN
      if (resume) begin m_halt <= 1'b0; m_req <= 1'b1; end
`endif
    end
  end

  always @(negedge clk) begin
    chk("m_req",      {15'd0, imem_req},    {15'd0, m_req});
    chk("m_valid",    {15'd0, instr_valid}, {15'd0, m_valid});
    chk("m_halted",   {15'd0, halted},      {15'd0, m_halt});
    chk("m_pc",       {8'd0, pc},           {8'd0, m_pc});
    chk("m_ir",       {Op_Code, Operands},  m_ir);
    if (m_req) chk("m_addr", {8'd0, imem_addr}, {8'd0, m_pc});
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b1; ack_en = 1'b1; force_ack = 1'b0;
    redirect_en = 1'b0; redirect_pc = 8'h00; resume = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = {8'h10, i[7:0]};
    mem[8'h10] = 16'h2ABC;
    mem[8'h11] = 16'h1234;
    mem[8'h40] = 16'h3000;
    mem[8'hFF] = 16'h5555;
    mem[8'h00] = 16'hF000;

    step();
    chk("rst_req",   {15'd0, imem_req}, 16'd0);
    chk("rst_pc",    {8'd0, pc},        {8'd0, RSTPC});
    chk("rst_addr",  {8'd0, imem_addr}, {8'd0, RSTPC});
    chk("rst_ir",    {Op_Code, Operands}, 16'h0000);
    step();
    rst = 1'b0;
    step();
    chk("first_req",  {15'd0, imem_req}, 16'd1);
    chk("first_addr", {8'd0, imem_addr}, 16'h0010);
    step();
    chk("issue_op",   {12'd0, Op_Code},  16'h0002);
    chk("issue_opnd", {4'd0, Operands},  16'h0ABC);
    chk("issue_vld",  {15'd0, instr_valid}, 16'd1);
    chk("issue_pc",   {8'd0, pc},        16'h0011);
    repeat (3) begin
      step();
      chk("stall_req",  {15'd0, imem_req}, 16'd0);
      chk("stall_op",   {Op_Code, Operands}, 16'h2ABC);
    end
    stall = 1'b0;
    step();
    chk("post_stall_addr", {8'd0, imem_addr}, 16'h0011);
    redirect_en = 1'b1; redirect_pc = 8'h40;   // ignored while in REQ
    step();
    chk("fetch2_op", {Op_Code, Operands}, 16'h1234);
    chk("fetch2_pc", {8'd0, pc},          16'h0012);
    step();
    chk("redir_addr", {8'd0, imem_addr},  16'h0040);
    redirect_en = 1'b0;
    step();
    chk("redir_pc",  {8'd0, pc},          16'h0041);
    redirect_en = 1'b1; redirect_pc = 8'hFF;
    step();
    chk("wrap_addr", {8'd0, imem_addr},   16'h00FF);
    redirect_en = 1'b0;
    step();
    chk("wrap_pc",   {8'd0, pc},          16'h0000);
    step();
    step();
    chk("halt_word", {Op_Code, Operands}, 16'hF000);
    redirect_en = 1'b1; redirect_pc = 8'h80;
    step();
    chk("halted",    {15'd0, halted},     16'd1);
    chk("halt_pc",   {8'd0, pc},          16'h0001);
    redirect_en = 1'b0;
    repeat (2) begin
      step();
      chk("halt_req", {15'd0, imem_req},  16'd0);
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
`ifdef HALT_RESUME_EN
    chk("resume_req",  {15'd0, imem_req}, 16'd1);
    chk("resume_addr", {8'd0, imem_addr}, 16'h0001);
`else
    chk("noresume_halt", {15'd0, halted}, 16'd1);
`endif
    step();

    ack_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("pre_rst_req", {15'd0, imem_req}, 16'd1);
    #2;
    rst = 1'b1; force_ack = 1'b1;
    #1;
    chk("async_req",   {15'd0, imem_req},    16'd0);
    chk("async_valid", {15'd0, instr_valid}, 16'd0);
    chk("async_pc",    {8'd0, pc},           {8'd0, RSTPC});
    step();
    chk("late_ack_ir", {Op_Code, Operands},  16'h0000);
    chk("late_ack_pc", {8'd0, pc},           {8'd0, RSTPC});
    rst = 1'b0; force_ack = 1'b0; ack_en = 1'b1;
    step();
    chk("restart_addr", {8'd0, imem_addr},   {8'd0, RSTPC});
    step();
    chk("restart_ir",  {Op_Code, Operands},  16'h2ABC);
    chk("restart_pc",  {8'd0, pc},           16'h0011);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
